// File: rtl/avl_pkt_fifo_if.sv
// Avalon-ST packet stream bundle (valid/ready, sop/eop framing).
// master drives the stream, slave accepts it.
interface avl_pkt_fifo_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  valid;
  logic                  ready;
  logic                  sop;
  logic                  eop;
  logic [DATA_WIDTH-1:0] data;

  modport master (
    output valid, sop, eop, data,
    input  ready
  );

  modport slave (
    input  valid, sop, eop, data,
    output ready
  );
endinterface

// File: rtl/avl_pkt_fifo.sv
// Store-and-forward Avalon-ST packet FIFO.
// Whole packets commit before release; bad packets are rewound and counted.
module avl_pkt_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_LOG2 = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  avl_pkt_fifo_if.slave         data_input,
  avl_pkt_fifo_if.master        data_output,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic [DEPTH_LOG2:0]   pkt_count,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic [CNT_WIDTH-1:0]  frame_err_count
);
  localparam int PW = DEPTH_LOG2 + 1;
  localparam int WW = DATA_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_PKT,
    WR_DROP
  } wr_state_t;

  wr_state_t state, state_nxt;

  logic [WW-1:0] mem [2**DEPTH_LOG2];
  logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr, pkt_start;
  logic [PW-1:0] base;

  logic vin, sop, eop;
  logic full, start_full;
  logic wr_en, rewind, set_start;
  logic do_commit, drop_inc, ferr_inc;

  logic [WW-1:0] q_word, skid_word, head;
  logic q_v, skid_v, out_v;
  logic eligible, rd_en, pop, move;
  logic sop_flag, pkt_dec;

  assign vin  = data_input.valid;
  assign sop  = data_input.sop;
  assign eop  = data_input.eop;
  assign full = (wr_ptr - rd_ptr) == DEPTH;

  // a restarting SOP lands at pkt_start when it aborts an open packet
  assign start_full = (state == WR_PKT)
                    ? ((pkt_start - rd_ptr) == DEPTH)
                    : full;

  assign base = rewind ? pkt_start : wr_ptr;

  assign data_input.ready = ~full;
  assign fill_level       = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) state <= WR_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (vin) begin
      unique case (state)
        WR_IDLE: begin
          if (sop)
            state_nxt = eop ? WR_IDLE
                      : (start_full ? WR_DROP : WR_PKT);
        end
        WR_PKT: begin
          if (sop)
            state_nxt = eop ? WR_IDLE
                      : (start_full ? WR_DROP : WR_PKT);
          else if (full)
            state_nxt = eop ? WR_IDLE : WR_DROP;
          else if (eop)
            state_nxt = WR_IDLE;
        end
        WR_DROP: begin
          if (sop)
            state_nxt = eop ? WR_IDLE
                      : (start_full ? WR_DROP : WR_PKT);
          else if (eop)
            state_nxt = WR_IDLE;
        end
        default: state_nxt = WR_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_en     = 1'b0;
    rewind    = 1'b0;
    set_start = 1'b0;
    do_commit = 1'b0;
    drop_inc  = 1'b0;
    ferr_inc  = 1'b0;
    if (vin) begin
      unique case (state)
        WR_IDLE, WR_DROP: begin
          if (sop) begin
            if (start_full) begin
              drop_inc = 1'b1;
            end else begin
              wr_en     = 1'b1;
              set_start = 1'b1;
              do_commit = eop;
            end
          end else if (state == WR_IDLE) begin
            ferr_inc = 1'b1;
          end
        end
        WR_PKT: begin
          if (sop) begin
            rewind   = 1'b1;
            drop_inc = 1'b1;
            if (!start_full) begin
              wr_en     = 1'b1;
              set_start = 1'b1;
              do_commit = eop;
            end
          end else if (full) begin
            rewind   = 1'b1;
            drop_inc = 1'b1;
          end else begin
            wr_en     = 1'b1;
            do_commit = eop;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr          <= '0;
      commit_ptr      <= '0;
      pkt_start       <= '0;
      drop_count      <= '0;
      frame_err_count <= '0;
      pkt_count       <= '0;
    end else begin
      wr_ptr <= wr_en ? base + PW'(1) : base;
      if (set_start)
        pkt_start <= base;
      if (do_commit)
        commit_ptr <= base + PW'(1);
      if (drop_inc && drop_count != '1)
        drop_count <= drop_count + CNT_WIDTH'(1);
      if (ferr_inc && frame_err_count != '1)
        frame_err_count <= frame_err_count + CNT_WIDTH'(1);
      if (do_commit && !pkt_dec)
        pkt_count <= pkt_count + PW'(1);
      else if (!do_commit && pkt_dec)
        pkt_count <= pkt_count - PW'(1);
    end
  end

  // q_word is the RAM read register; skid_word holds the older word on stall
  assign eligible = rd_ptr != commit_ptr;
  assign rd_en    = eligible & ~(q_v & skid_v);
  assign out_v    = q_v | skid_v;
  assign head     = skid_v ? skid_word : q_word;
  assign pop      = out_v & data_output.ready;
  assign move     = q_v & ~skid_v & ~pop & rd_en;
  assign pkt_dec  = pop & head[WW-1];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[base[DEPTH_LOG2-1:0]] <= {eop, data_input.data};
    if (rd_en)
      q_word <= mem[rd_ptr[DEPTH_LOG2-1:0]];
    if (move)
      skid_word <= q_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      q_v      <= 1'b0;
      skid_v   <= 1'b0;
      sop_flag <= 1'b1;
    end else begin
      if (rd_en)
        rd_ptr <= rd_ptr + PW'(1);
      if (rd_en)
        q_v <= 1'b1;
      else if (pop && !skid_v)
        q_v <= 1'b0;
      if (skid_v && pop)
        skid_v <= 1'b0;
      else if (move)
        skid_v <= 1'b1;
      if (pop)
        sop_flag <= head[WW-1];
    end
  end

  assign data_output.valid = out_v;
  assign data_output.data  = out_v ? head[DATA_WIDTH-1:0] : '0;
  assign data_output.eop   = out_v & head[WW-1];
  assign data_output.sop   = out_v & sop_flag;

endmodule

// File: tb/tb_avl_pkt_fifo.sv
// Bench for avl_pkt_fifo: directed test-plan steps plus random packets
// checked against a packet-level queue model.
module tb_avl_pkt_fifo;
  localparam int DW    = 16;
  localparam int DL    = 4;
  localparam int CW    = 16;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [DL:0]   fill_level, pkt_count;
  logic [CW-1:0] drop_count, frame_err_count;

  avl_pkt_fifo_if #(.DATA_WIDTH(DW)) din ();
  avl_pkt_fifo_if #(.DATA_WIDTH(DW)) dout ();

  avl_pkt_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH_LOG2(DL),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .data_input(din),
    .data_output(dout),
    .fill_level(fill_level),
    .pkt_count(pkt_count),
    .drop_count(drop_count),
    .frame_err_count(frame_err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  // model: committed words awaiting output as {sop,eop,data}
  logic [17:0] expq[$];
  logic [17:0] cur[$];
  bit in_pkt, dropping;
  int m_drop, m_ferr;
  int last_cyc;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_full();
    return (expq.size() + cur.size()) >= DEPTH;
  endfunction

  function automatic int m_pkts();
    int n = 0;
    foreach (expq[i]) if (expq[i][16]) n++;
    return n;
  endfunction

  function automatic void m_commit();
    foreach (cur[i]) expq.push_back(cur[i]);
    cur.delete();
    in_pkt = 0;
  endfunction

  function automatic void m_clear();
    expq.delete();
    cur.delete();
    in_pkt = 0;
    dropping = 0;
    m_drop = 0;
    m_ferr = 0;
  endfunction

  function automatic void m_word(bit s, bit e, logic [15:0] d);
    if (s) begin
      if (in_pkt) begin
        m_drop++;
        cur.delete();
      end
      in_pkt = 0;
      dropping = 0;
      if (m_full()) begin
        m_drop++;
        dropping = !e;
      end else begin
        cur.push_back({1'b1, e, d});
        if (e) m_commit();
        else in_pkt = 1;
      end
    end else if (in_pkt) begin
      if (m_full()) begin
        m_drop++;
        cur.delete();
        in_pkt = 0;
        dropping = !e;
      end else begin
        cur.push_back({1'b0, e, d});
        if (e) m_commit();
      end
    end else if (dropping) begin
      if (e) dropping = 0;
    end else begin
      m_ferr++;
    end
  endfunction

  // output monitor: scoreboard plus Avalon hold rule
  logic [17:0] held;
  bit stall = 0;
  always @(negedge clk) begin
    logic [17:0] w;
    w = {dout.sop, dout.eop, dout.data};
    if (reset) begin
      stall = 0;
    end else begin
      if (stall) begin
        chk("hold_valid", 64'(dout.valid), 64'(1));
        chk("hold_word", 64'(w), 64'(held));
      end
      if (dout.valid && dout.ready) begin
        if (expq.size() == 0)
          chk("spurious_out", 64'(expq.size()), 64'(1));
        else
          chk("out_word", 64'(w), 64'(expq.pop_front()));
      end
      stall = dout.valid && !dout.ready;
      held = w;
    end
  end

  task automatic send(bit s, bit e, logic [15:0] d);
    m_word(s, e, d);
    din.valid = 1'b1;
    din.sop = s;
    din.eop = e;
    din.data = d;
    last_cyc = cyc;
    @(posedge clk);
    #1;
    din.valid = 1'b0;
    din.sop = 1'b0;
    din.eop = 1'b0;
    din.data = '0;
  endtask

  task automatic send_pkt(int len, bit rr);
    for (int i = 0; i < len; i++) begin
      if (rr) dout.ready = 1'($urandom_range(0, 1));
      send(i == 0, i == len - 1, 16'($urandom));
    end
  endtask

  task automatic drain(int budget, bit rr);
    int n = 0;
    while (expq.size() != 0 && n < budget) begin
      dout.ready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_done", 64'(expq.size()), 64'(0));
    dout.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_counts(string t);
    chk({t, "_drop"}, 64'(drop_count), 64'(m_drop));
    chk({t, "_ferr"}, 64'(frame_err_count), 64'(m_ferr));
    chk({t, "_pkts"}, 64'(pkt_count), 64'(m_pkts()));
  endtask

  task automatic chk_reset_state(string t);
    chk({t, "_ovalid"}, 64'(dout.valid), 64'(0));
    chk({t, "_osop"}, 64'(dout.sop), 64'(0));
    chk({t, "_oeop"}, 64'(dout.eop), 64'(0));
    chk({t, "_odata"}, 64'(dout.data), 64'(0));
    chk({t, "_iready"}, 64'(din.ready), 64'(1));
    chk({t, "_fill"}, 64'(fill_level), 64'(0));
    chk({t, "_pkt"}, 64'(pkt_count), 64'(0));
    chk({t, "_drop"}, 64'(drop_count), 64'(0));
    chk({t, "_ferr"}, 64'(frame_err_count), 64'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    din.valid = 1'b0;
    din.sop = 1'b0;
    din.eop = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_clear();
  endtask

  task automatic wait_room(int need);
    int n = 0;
    dout.ready = 1'b1;
    while (expq.size() + need > DEPTH && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("room_wait", 64'(n < 200), 64'(1));
  endtask

  initial begin
    int first, n, len, alen;
    din.valid = 1'b0;
    din.sop = 1'b0;
    din.eop = 1'b0;
    din.data = '0;
    dout.ready = 1'b0;
    m_clear();

    // reset values
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("rst");
    reset = 1'b0;

    // 12-word packet, ready high: latency and pkt_count
    dout.ready = 1'b1;
    send_pkt(12, 0);
    chk("t1_fill", 64'(fill_level), 64'(12));
    chk("t1_pkt", 64'(pkt_count), 64'(1));
    first = -1;
    for (int i = 0; i < 6; i++) begin
      if (dout.valid && first < 0) first = cyc;
      @(posedge clk);
      #1;
    end
    chk("t1_latency", 64'(first), 64'(last_cyc + 2));
    drain(100, 0);
    chk("t1_pkt_end", 64'(pkt_count), 64'(0));
    chk("t1_fill_end", 64'(fill_level), 64'(0));

    // same packet stalled 20 clk, then back-to-back release
    dout.ready = 1'b0;
    send_pkt(12, 0);
    chk("t2_fill", 64'(fill_level), 64'(12));
    repeat (20) @(posedge clk);
    #1;
    chk("t2_head", 64'({dout.sop, dout.eop, dout.data}), 64'(expq[0]));
    chk("t2_queued", 64'(expq.size()), 64'(12));
    dout.ready = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (dout.valid) n++;
      @(posedge clk);
      #1;
    end
    chk("t2_b2b", 64'(n), 64'(12));
    drain(100, 0);
    chk("t2_fill_end", 64'(fill_level), 64'(0));
    chk_counts("t2");

    // overflow: 20-word packet into 16-deep FIFO
    do_reset();
    send_pkt(20, 0);
    chk("t3_drop", 64'(drop_count), 64'(1));
    chk("t3_fill", 64'(fill_level), 64'(0));
    send_pkt(4, 0);
    drain(100, 0);
    chk_counts("t3");

    // SOP abort at word 5
    do_reset();
    for (int i = 0; i < 5; i++) send(i == 0, 1'b0, 16'(16'h100 + i));
    send_pkt(6, 0);
    drain(100, 0);
    chk("t4_drop", 64'(drop_count), 64'(1));
    chk_counts("t4");

    // words outside a packet
    do_reset();
    for (int i = 0; i < 3; i++) send(1'b0, 1'b0, 16'(16'h200 + i));
    chk("t5_ferr", 64'(frame_err_count), 64'(3));
    chk("t5_fill", 64'(fill_level), 64'(0));

    // pointer wrap, then reset mid-packet
    do_reset();
    send_pkt(12, 0);
    drain(100, 0);
    send_pkt(10, 0);
    send_pkt(10, 0);
    drain(200, 0);
    chk_counts("t6");
    dout.ready = 1'b0;
    send_pkt(4, 0);
    for (int i = 0; i < 5; i++) send(i == 0, 1'b0, 16'($urandom));
    chk("t6_pre_valid", 64'(dout.valid), 64'(1));
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_state("t6_rst");
    reset = 1'b0;
    m_clear();
    dout.ready = 1'b1;

    // random packets, aborts, stray words and back-pressure
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 10);
      alen = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 4) : 0;
      wait_room(len + alen);
      if ($urandom_range(0, 5) == 0)
        for (int i = 0; i < $urandom_range(1, 3); i++)
          send(1'b0, 1'($urandom_range(0, 1)), 16'($urandom));
      for (int i = 0; i < alen; i++) send(i == 0, 1'b0, 16'($urandom));
      send_pkt(len, 1);
      chk_counts("rnd");
      repeat ($urandom_range(0, 3)) begin
        dout.ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
    end
    drain(3000, 1);
    chk_counts("rnd_end");
    chk("rnd_fill_end", 64'(fill_level), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
